// File: rtl/rx_ctrl_pkg.sv
// Shared state encoding, opcode constants and length check for the rx_burst_control command decoder.
package rx_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_WADDR    = 4'd1,
    ST_WDATA    = 4'd2,
    ST_RADDR    = 4'd3,
    ST_OPA      = 4'd4,
    ST_OPB      = 4'd5,
    ST_FUN      = 4'd6,
    ST_BW_ADDR  = 4'd7,
    ST_BW_LEN   = 4'd8,
    ST_BW_DATA  = 4'd9,
    ST_BR_ADDR  = 4'd10,
    ST_BR_LEN   = 4'd11,
    ST_BR_ISSUE = 4'd12
  } state_e;

  localparam logic [7:0] OP_WR     = 8'hAA;
  localparam logic [7:0] OP_RD     = 8'hBB;
  localparam logic [7:0] OP_ALU_OP = 8'hCC;
  localparam logic [7:0] OP_ALU    = 8'hDD;
  localparam logic [7:0] OP_BWR    = 8'hEE;
  localparam logic [7:0] OP_BRD    = 8'hEF;

  // A burst of zero frames or longer than the configured limit is rejected.
  function automatic logic len_ok(input logic [7:0] len, input int max_burst);
    return (len != 8'd0) && (int'(len) <= max_burst);
  endfunction

endpackage

// File: rtl/rx_ctrl_timer.sv
// Inter-frame timeout counter: counts enabled cycles, clears on clr or when disabled,
// and flags expiry on the TIMEOUT_CYC-th silent cycle.
module rx_ctrl_timer #(
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr || !en) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_W'(TIMEOUT_CYC - 1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = en && !clr && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/rx_burst_control.sv
// Command decoder from UART frames to register-file / ALU / clock-gate controls with burst access.
// Optional inter-frame timeout is enabled by defining RX_CTRL_TIMEOUT_EN.
module rx_burst_control
  import rx_ctrl_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int DEPTH       = 16,
  parameter int MAX_BURST   = 8,
  parameter int OPA_ADDR    = 0,
  parameter int OPB_ADDR    = 1,
  parameter int TIMEOUT_CYC = 4096,
  localparam int ADDR_W     = $clog2(DEPTH)
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic [WIDTH-1:0]  Rx_P_Data,
  input  logic              RxValid,
  input  logic              Rd_Ready,
  output logic              ALU_EN,
  output logic [3:0]        ALU_FUN,
  output logic [ADDR_W-1:0] Reg_File_Adress,
  output logic              WrEN,
  output logic              RdEN,
  output logic [WIDTH-1:0]  WrData,
  output logic              CLK_GATE_EN,
  output logic              Busy,
  output logic              Cmd_Err
);

  if (WIDTH < 8 || MAX_BURST < 1 || MAX_BURST > 255 || TIMEOUT_CYC < 1) begin : g_param_chk
    $error("rx_burst_control: illegal parameter combination");
  end

  // Handshake: RxValid is a one-cycle strobe with no back-pressure; Rd_Ready is sampled
  // only while a burst read is issuing, and each cycle it is high yields one RdEN next cycle.

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  baddr_q, baddr_d;
  logic [7:0]         cnt_q, cnt_d;
  logic               alu_en_q, alu_en_d;
  logic [3:0]         alu_fun_q, alu_fun_d;
  logic [ADDR_W-1:0]  adr_q, adr_d;
  logic               wr_en_q, wr_en_d;
  logic               rd_en_q, rd_en_d;
  logic [WIDTH-1:0]   wr_data_q, wr_data_d;
  logic               gate_q, gate_d;
  logic               cmd_err_q, cmd_err_d;
  logic               tmr_expire;

  logic [ADDR_W-1:0]  frame_addr;
  logic [7:0]         frame_len;

  assign frame_addr = Rx_P_Data[ADDR_W-1:0];
  assign frame_len  = Rx_P_Data[7:0];

  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
    if (a == ADDR_W'(DEPTH - 1)) begin
      return '0;
    end
    return a + ADDR_W'(1);
  endfunction

`ifdef RX_CTRL_TIMEOUT_EN
  logic tmr_en;

  // Burst-read issue is paced by Rd_Ready, not by incoming frames, so it never times out.
  assign tmr_en = (state_q != ST_IDLE) && (state_q != ST_BR_ISSUE);

  rx_ctrl_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timer (
    .clk    (CLK),
    .rst_n  (Reset),
    .clr    (RxValid),
    .en     (tmr_en),
    .expire (tmr_expire)
  );
`else
  assign tmr_expire = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    baddr_d   = baddr_q;
    cnt_d     = cnt_q;
    alu_en_d  = 1'b0;
    alu_fun_d = alu_fun_q;
    adr_d     = adr_q;
    wr_en_d   = 1'b0;
    rd_en_d   = 1'b0;
    wr_data_d = wr_data_q;
    cmd_err_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (RxValid) begin
          if (Rx_P_Data == WIDTH'(OP_WR)) begin
            state_d = ST_WADDR;
          end else if (Rx_P_Data == WIDTH'(OP_RD)) begin
            state_d = ST_RADDR;
          end else if (Rx_P_Data == WIDTH'(OP_ALU_OP)) begin
            state_d = ST_OPA;
          end else if (Rx_P_Data == WIDTH'(OP_ALU)) begin
            state_d = ST_FUN;
          end else if (Rx_P_Data == WIDTH'(OP_BWR)) begin
            state_d = ST_BW_ADDR;
          end else if (Rx_P_Data == WIDTH'(OP_BRD)) begin
            state_d = ST_BR_ADDR;
          end else begin
            cmd_err_d = 1'b1;
          end
        end
      end
      ST_WADDR: begin
        if (RxValid) begin
          baddr_d = frame_addr;
          state_d = ST_WDATA;
        end
      end
      ST_WDATA: begin
        if (RxValid) begin
          wr_en_d   = 1'b1;
          adr_d     = baddr_q;
          wr_data_d = Rx_P_Data;
          state_d   = ST_IDLE;
        end
      end
      ST_RADDR: begin
        if (RxValid) begin
          rd_en_d = 1'b1;
          adr_d   = frame_addr;
          state_d = ST_IDLE;
        end
      end
      ST_OPA: begin
        if (RxValid) begin
          wr_en_d   = 1'b1;
          adr_d     = ADDR_W'(OPA_ADDR);
          wr_data_d = Rx_P_Data;
          state_d   = ST_OPB;
        end
      end
      ST_OPB: begin
        if (RxValid) begin
          wr_en_d   = 1'b1;
          adr_d     = ADDR_W'(OPB_ADDR);
          wr_data_d = Rx_P_Data;
          state_d   = ST_FUN;
        end
      end
      ST_FUN: begin
        if (RxValid) begin
          alu_en_d  = 1'b1;
          alu_fun_d = Rx_P_Data[3:0];
          state_d   = ST_IDLE;
        end
      end
      ST_BW_ADDR: begin
        if (RxValid) begin
          baddr_d = frame_addr;
          state_d = ST_BW_LEN;
        end
      end
      ST_BW_LEN: begin
        if (RxValid) begin
          if (len_ok(frame_len, MAX_BURST)) begin
            cnt_d   = frame_len;
            state_d = ST_BW_DATA;
          end else begin
            cmd_err_d = 1'b1;
            state_d   = ST_IDLE;
          end
        end
      end
      ST_BW_DATA: begin
        if (RxValid) begin
          wr_en_d   = 1'b1;
          adr_d     = baddr_q;
          wr_data_d = Rx_P_Data;
          baddr_d   = next_addr(baddr_q);
          cnt_d     = cnt_q - 8'd1;
          if (cnt_q == 8'd1) begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_BR_ADDR: begin
        if (RxValid) begin
          baddr_d = frame_addr;
          state_d = ST_BR_LEN;
        end
      end
      ST_BR_LEN: begin
        if (RxValid) begin
          if (len_ok(frame_len, MAX_BURST)) begin
            cnt_d   = frame_len;
            state_d = ST_BR_ISSUE;
          end else begin
            cmd_err_d = 1'b1;
            state_d   = ST_IDLE;
          end
        end
      end
      ST_BR_ISSUE: begin
        // A stray frame wins over Rd_Ready so the error never coincides with a read.
        if (RxValid) begin
          cmd_err_d = 1'b1;
        end else if (Rd_Ready) begin
          rd_en_d = 1'b1;
          adr_d   = baddr_q;
          baddr_d = next_addr(baddr_q);
          cnt_d   = cnt_q - 8'd1;
          if (cnt_q == 8'd1) begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (tmr_expire) begin
      state_d   = ST_IDLE;
      cmd_err_d = 1'b1;
    end

    // Gated clock runs while the function frame is awaited and through the ALU_EN cycle.
    gate_d = (state_d == ST_FUN) || alu_en_d;
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q   <= ST_IDLE;
      baddr_q   <= '0;
      cnt_q     <= '0;
      alu_en_q  <= 1'b0;
      alu_fun_q <= '0;
      adr_q     <= '0;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      wr_data_q <= '0;
      gate_q    <= 1'b0;
      cmd_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      baddr_q   <= baddr_d;
      cnt_q     <= cnt_d;
      alu_en_q  <= alu_en_d;
      alu_fun_q <= alu_fun_d;
      adr_q     <= adr_d;
      wr_en_q   <= wr_en_d;
      rd_en_q   <= rd_en_d;
      wr_data_q <= wr_data_d;
      gate_q    <= gate_d;
      cmd_err_q <= cmd_err_d;
    end
  end

  assign ALU_EN          = alu_en_q;
  assign ALU_FUN         = alu_fun_q;
  assign Reg_File_Adress = adr_q;
  assign WrEN            = wr_en_q;
  assign RdEN            = rd_en_q;
  assign WrData          = wr_data_q;
  assign CLK_GATE_EN     = gate_q;
  assign Busy            = (state_q != ST_IDLE);
  assign Cmd_Err         = cmd_err_q;

endmodule

// File: tb/tb_rx_burst_control.sv
// Bench for rx_burst_control: frame-queue command model checked every cycle plus literal checks.
module tb_rx_burst_control;

  localparam int W     = 8;
  localparam int DEPTH = 16;
  localparam int MAXB  = 8;
  localparam int TO    = 64;

  logic         CLK;
  logic         Reset;
  logic [W-1:0] Rx_P_Data;
  logic         RxValid;
  logic         Rd_Ready;
  logic         ALU_EN;
  logic [3:0]   ALU_FUN;
  logic [3:0]   Reg_File_Adress;
  logic         WrEN;
  logic         RdEN;
  logic [W-1:0] WrData;
  logic         CLK_GATE_EN;
  logic         Busy;
  logic         Cmd_Err;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 0;

  rx_burst_control #(
    .WIDTH       (W),
    .DEPTH       (DEPTH),
    .MAX_BURST   (MAXB),
    .OPA_ADDR    (0),
    .OPB_ADDR    (1),
    .TIMEOUT_CYC (TO)
  ) dut (
    .CLK             (CLK),
    .Reset           (Reset),
    .Rx_P_Data       (Rx_P_Data),
    .RxValid         (RxValid),
    .Rd_Ready        (Rd_Ready),
    .ALU_EN          (ALU_EN),
    .ALU_FUN         (ALU_FUN),
    .Reg_File_Adress (Reg_File_Adress),
    .WrEN            (WrEN),
    .RdEN            (RdEN),
    .WrData          (WrData),
    .CLK_GATE_EN     (CLK_GATE_EN),
    .Busy            (Busy),
    .Cmd_Err         (Cmd_Err)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Command model: frames of the current command are collected in a queue and the
  // command's effect is decided from the opcode and how many frames have arrived.
  logic [7:0] m_q[$];
  int m_rd_left = 0;
  int m_addr    = 0;
  int m_silent  = 0;
  bit e_wr = 0, e_rd = 0, e_alu = 0, e_err = 0, e_gate = 0, e_busy = 0;
  int e_addr = 0;
  int e_data = 0;
  int e_fun  = 0;

  function automatic bit bad_len(input logic [7:0] len);
    return (len == 8'd0) || (int'(len) > MAXB);
  endfunction

  task automatic model_step();
    int n;
    int k;
    logic [7:0] op;
    e_wr = 0; e_rd = 0; e_alu = 0; e_err = 0;
    if (m_rd_left > 0) begin
      if (RxValid) begin
        e_err = 1;
      end else if (Rd_Ready) begin
        e_rd = 1;
        e_addr = m_addr;
        m_addr = (m_addr + 1) % DEPTH;
        m_rd_left--;
      end
    end else if (RxValid) begin
      m_silent = 0;
      m_q.push_back(Rx_P_Data);
      n = m_q.size();
      op = m_q[0];
      case (op)
        8'hAA: if (n == 3) begin
          e_wr = 1; e_addr = int'(m_q[1]) % DEPTH; e_data = int'(m_q[2]); m_q.delete();
        end
        8'hBB: if (n == 2) begin
          e_rd = 1; e_addr = int'(m_q[1]) % DEPTH; m_q.delete();
        end
        8'hCC: begin
          if (n == 2) begin e_wr = 1; e_addr = 0; e_data = int'(m_q[1]); end
          if (n == 3) begin e_wr = 1; e_addr = 1; e_data = int'(m_q[2]); end
          if (n == 4) begin e_alu = 1; e_fun = int'(m_q[3]) % 16; m_q.delete(); end
        end
        8'hDD: if (n == 2) begin
          e_alu = 1; e_fun = int'(m_q[1]) % 16; m_q.delete();
        end
        8'hEE: begin
          if (n == 3 && bad_len(m_q[2])) begin
            e_err = 1; m_q.delete();
          end else if (n >= 4) begin
            k = n - 4;
            e_wr = 1; e_addr = (int'(m_q[1]) + k) % DEPTH; e_data = int'(m_q[n-1]);
            if (k == int'(m_q[2]) - 1) m_q.delete();
          end
        end
        8'hEF: if (n == 3) begin
          if (bad_len(m_q[2])) begin
            e_err = 1;
          end else begin
            m_rd_left = int'(m_q[2]);
            m_addr = int'(m_q[1]) % DEPTH;
          end
          m_q.delete();
        end
        default: begin
          e_err = 1; m_q.delete();
        end
      endcase
    end else if (m_q.size() > 0) begin
`ifdef RX_CTRL_TIMEOUT_EN
      m_silent++;
      if (m_silent == TO) begin
        e_err = 1; m_q.delete();
      end
`endif
    end
    e_busy = (m_q.size() > 0) || (m_rd_left > 0);
    e_gate = e_alu;
    if (m_q.size() == 3 && m_q[0] == 8'hCC) e_gate = 1;
    if (m_q.size() == 1 && m_q[0] == 8'hDD) e_gate = 1;
  endtask

  always @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      m_q.delete();
      m_rd_left = 0; m_addr = 0; m_silent = 0;
      e_wr = 0; e_rd = 0; e_alu = 0; e_err = 0; e_gate = 0; e_busy = 0;
      e_addr = 0; e_data = 0; e_fun = 0;
    end else begin
      model_step();
    end
  end

  // scoreboard compare, every cycle on the falling edge
  always @(negedge CLK) begin
    if (chk_on) begin
      chk("m_wren", 32'(WrEN), 32'(e_wr));
      chk("m_rden", 32'(RdEN), 32'(e_rd));
      chk("m_alu_en", 32'(ALU_EN), 32'(e_alu));
      chk("m_cmd_err", 32'(Cmd_Err), 32'(e_err));
      chk("m_gate", 32'(CLK_GATE_EN), 32'(e_gate));
      chk("m_busy", 32'(Busy), 32'(e_busy));
      chk("m_addr", 32'(Reg_File_Adress), 32'(e_addr));
      if (e_wr) chk("m_wrdata", 32'(WrData), 32'(e_data));
      if (e_alu) chk("m_alu_fun", 32'(ALU_FUN), 32'(e_fun));
    end
  end

  // driver
  task automatic send(input logic [7:0] v);
    RxValid = 1'b1;
    Rx_P_Data = v;
    @(negedge CLK);
    RxValid = 1'b0;
    Rx_P_Data = '0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_outs"}, {WrEN, RdEN, ALU_EN, Cmd_Err, CLK_GATE_EN, Busy}, 32'd0);
    chk({tag, "_addr"}, 32'(Reg_File_Adress), 32'd0);
    chk({tag, "_data_fun"}, {WrData, ALU_FUN}, 32'd0);
  endtask

  initial begin
    Reset = 1'b1; RxValid = 1'b0; Rx_P_Data = '0; Rd_Ready = 1'b0;
    #1 Reset = 1'b0;
    repeat (2) @(negedge CLK);
    chk_all_zero("reset");
    Reset = 1'b1;
    chk_on = 1;
    @(negedge CLK);

    // single write then read back
    send(8'hAA); send(8'h05);
    chk("wr_not_early", 32'(WrEN), 32'd0);
    send(8'h3C);
    chk("wr_pulse", 32'(WrEN), 32'd1);
    chk("wr_addr", 32'(Reg_File_Adress), 32'd5);
    chk("wr_data", 32'(WrData), 32'h3C);
    send(8'hBB); send(8'h05);
    chk("rd_pulse", 32'(RdEN), 32'd1);
    chk("rd_addr", 32'(Reg_File_Adress), 32'd5);

    // ALU with operands, then without
    send(8'hCC); send(8'h11);
    chk("opa_wr", {WrEN, 4'(Reg_File_Adress), WrData}, {1'b1, 4'd0, 8'h11});
    send(8'h22);
    chk("opb_wr", {WrEN, 4'(Reg_File_Adress), WrData}, {1'b1, 4'd1, 8'h22});
    chk("gate_wait_fun", 32'(CLK_GATE_EN), 32'd1);
    send(8'h03);
    chk("alu_pulse", {ALU_EN, ALU_FUN, CLK_GATE_EN}, {1'b1, 4'd3, 1'b1});
    @(negedge CLK);
    chk("gate_off", {ALU_EN, CLK_GATE_EN}, 32'd0);
    send(8'hDD); send(8'h07);
    chk("alu_no_op", {ALU_EN, ALU_FUN}, {1'b1, 4'd7});

    // burst write across the address wrap
    send(8'hEE); send(8'h0E); send(8'h04);
    send(8'hA1); chk("bw_addr0", 32'(Reg_File_Adress), 32'd14);
    send(8'hA2); chk("bw_addr1", 32'(Reg_File_Adress), 32'd15);
    send(8'hA3); chk("bw_addr2", 32'(Reg_File_Adress), 32'd0);
    send(8'hA4); chk("bw_addr3", 32'(Reg_File_Adress), 32'd1);
    chk("bw_last", {WrEN, Busy, WrData}, {1'b1, 1'b0, 8'hA4});

    // burst read with Rd_Ready stalls
    send(8'hEF); send(8'h02); send(8'h03);
    Rd_Ready = 1'b1; @(negedge CLK);
    chk("br_rd0", {RdEN, 4'(Reg_File_Adress)}, {1'b1, 4'd2});
    Rd_Ready = 1'b0; @(negedge CLK);
    chk("br_stall0", 32'(RdEN), 32'd0);
    @(negedge CLK);
    chk("br_stall1", {RdEN, Busy}, {1'b0, 1'b1});
    Rd_Ready = 1'b1; @(negedge CLK);
    chk("br_rd1", {RdEN, 4'(Reg_File_Adress)}, {1'b1, 4'd3});
    @(negedge CLK);
    chk("br_rd2", {RdEN, 4'(Reg_File_Adress), Busy}, {1'b1, 4'd4, 1'b0});
    @(negedge CLK);
    chk("br_done", 32'(RdEN), 32'd0);

    // stray frame during burst read issue
    Rd_Ready = 1'b0;
    send(8'hEF); send(8'h08); send(8'h02);
    Rd_Ready = 1'b1;
    send(8'h77);
    chk("br_drop", {Cmd_Err, RdEN}, {1'b1, 1'b0});
    @(negedge CLK);
    chk("br_after_drop0", {RdEN, 4'(Reg_File_Adress)}, {1'b1, 4'd8});
    @(negedge CLK);
    chk("br_after_drop1", {RdEN, 4'(Reg_File_Adress), Busy}, {1'b1, 4'd9, 1'b0});
    Rd_Ready = 1'b0;
    repeat (2) @(negedge CLK);
    chk("addr_hold", 32'(Reg_File_Adress), 32'd9);

    // errors
    send(8'h55);
    chk("bad_op", {Cmd_Err, Busy}, {1'b1, 1'b0});
    send(8'hEE); send(8'h00); send(8'h00);
    chk("len_zero", {Cmd_Err, WrEN, Busy}, {1'b1, 1'b0, 1'b0});
    send(8'hEE); send(8'h00); send(8'h09);
    chk("len_over", {Cmd_Err, WrEN, Busy}, {1'b1, 1'b0, 1'b0});

    // longest legal burst
    send(8'hEE); send(8'h0F); send(8'h08);
    for (int i = 0; i < 8; i++) send(8'(8'h30 + i));
    chk("bw_max_last", {WrEN, 4'(Reg_File_Adress), Busy, WrData}, {1'b1, 4'd6, 1'b0, 8'h37});

    // reset in the middle of a burst write
    send(8'hEE); send(8'h03); send(8'h04);
    send(8'hB1);
    #2 Reset = 1'b0;
    #1 chk_all_zero("mid_reset");
    @(negedge CLK);
    Reset = 1'b1;
    @(negedge CLK);
    send(8'hBB); send(8'h03);
    chk("post_reset_rd", {RdEN, 4'(Reg_File_Adress), Cmd_Err}, {1'b1, 4'd3, 1'b0});

`ifdef RX_CTRL_TIMEOUT_EN
    send(8'hAA); send(8'h05);
    repeat (TO - 1) @(negedge CLK);
    chk("to_before", {Cmd_Err, Busy}, {1'b0, 1'b1});
    @(negedge CLK);
    chk("to_fire", {Cmd_Err, Busy, WrEN}, {1'b1, 1'b0, 1'b0});
    @(negedge CLK);
    send(8'hBB); send(8'h05);
    chk("to_recover", {RdEN, 4'(Reg_File_Adress)}, {1'b1, 4'd5});
`endif

    repeat (3) @(negedge CLK);
    chk_on = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
